// File: rtl/flush_ctrl.sv
// flush_ctrl: pipeline recovery sequencer (flush pulse, drain stall, held redirect).
// Define FLUSH_CTRL_STATS_EN to build the saturating statistics counters.
module flush_ctrl #(
    parameter int XLEN         = 64,
    parameter int ID_W         = 8,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mispred_valid_i,
    input  logic [ID_W-1:0] mispred_id_i,
    input  logic [XLEN-1:0] mispred_target_i,
    input  logic            exc_valid_i,
    input  logic [XLEN-1:0] exc_pc_i,
    output logic            flush_o,
    output logic            flush_all_o,
    output logic [ID_W-1:0] flush_id_o,
    output logic            stall_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    input  logic            redirect_ready_i,
    output logic            busy_o,
    output logic [31:0]     stat_mispred_o,
    output logic [31:0]     stat_exc_o,
    output logic [31:0]     stat_stall_o
);
    typedef enum logic [1:0] {IDLE, FLUSH, HOLD, REDIRECT} state_t;

    localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

    state_t          state_q, state_d;
    logic            trap_q, trap_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [ID_W-1:0] age_diff;
    logic            acc;

    // Wrapping age compare: new id is older when (new - pending) has its MSB set.
    assign age_diff = mispred_id_i - id_q;
    assign acc = exc_valid_i || (mispred_valid_i && (state_q == IDLE ||
                 ((state_q == HOLD || state_q == REDIRECT) && !trap_q && age_diff[ID_W-1])));

    always_comb begin
        state_d = state_q;
        trap_d  = trap_q;
        id_d    = id_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (acc) begin
            state_d = FLUSH;
            trap_d  = exc_valid_i;
            id_d    = exc_valid_i ? '0 : mispred_id_i;
            pc_d    = exc_valid_i ? exc_pc_i : mispred_target_i;
        end else if (state_q == FLUSH) begin
            state_d = HOLD;
            cnt_d   = CNT_INIT;
        end else if (state_q == HOLD) begin
            state_d = cnt_q == 4'd0 ? REDIRECT : HOLD;
            cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
        end else if (state_q == REDIRECT && redirect_ready_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            trap_q  <= 1'b0;
            id_q    <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_d;
            id_q    <= id_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign flush_o          = state_q == FLUSH;
    assign flush_all_o      = flush_o && trap_q;
    assign flush_id_o       = (flush_o && !trap_q) ? id_q : '0;
    assign stall_o          = state_q != IDLE;
    assign busy_o           = state_q != IDLE;
    assign redirect_valid_o = state_q == REDIRECT;
    assign redirect_pc_o    = redirect_valid_o ? pc_q : '0;

`ifdef FLUSH_CTRL_STATS_EN
    logic [31:0] smp_q, sex_q, sst_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_q <= '0;
            sex_q <= '0;
            sst_q <= '0;
        end else begin
            if (flush_o && !trap_q && !(&smp_q)) smp_q <= smp_q + 32'd1;
            if (flush_o && trap_q && !(&sex_q))  sex_q <= sex_q + 32'd1;
            if (stall_o && !(&sst_q))            sst_q <= sst_q + 32'd1;
        end
    end

    assign stat_mispred_o = smp_q;
    assign stat_exc_o     = sex_q;
    assign stat_stall_o   = sst_q;
`else
    assign stat_mispred_o = '0;
    assign stat_exc_o     = '0;
    assign stat_stall_o   = '0;
`endif
endmodule

// File: tb/tb_flush_ctrl.sv
// tb_flush_ctrl: directed literal checks plus randomized run against a timeline model.
module tb_flush_ctrl;
    localparam int XLEN  = 64;
    localparam int ID_W  = 8;
    localparam int DRAIN = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mispred_valid_i = 1'b0;
    logic [ID_W-1:0] mispred_id_i = '0;
    logic [XLEN-1:0] mispred_target_i = '0;
    logic            exc_valid_i = 1'b0;
    logic [XLEN-1:0] exc_pc_i = '0;
    logic            redirect_ready_i = 1'b1;
    logic            flush_o, flush_all_o, stall_o, redirect_valid_o, busy_o;
    logic [ID_W-1:0] flush_id_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic [31:0]     stat_mispred_o, stat_exc_o, stat_stall_o;

    int tests = 0;
    int fails = 0;

    flush_ctrl #(.XLEN(XLEN), .ID_W(ID_W), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst(rst),
        .mispred_valid_i(mispred_valid_i), .mispred_id_i(mispred_id_i),
        .mispred_target_i(mispred_target_i),
        .exc_valid_i(exc_valid_i), .exc_pc_i(exc_pc_i),
        .flush_o(flush_o), .flush_all_o(flush_all_o), .flush_id_o(flush_id_o),
        .stall_o(stall_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o), .redirect_ready_i(redirect_ready_i),
        .busy_o(busy_o), .stat_mispred_o(stat_mispred_o),
        .stat_exc_o(stat_exc_o), .stat_stall_o(stat_stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
        end
    endtask

    function automatic bit older(input logic [ID_W-1:0] a, input logic [ID_W-1:0] b);
        logic [ID_W-1:0] d;
        d = a - b;
        return d[ID_W-1];
    endfunction

    // Model: a pending event is a timeline measured from its latch cycle.
    // age 0 = flush pulse, 1..DRAIN = drain, >DRAIN = redirect offered.
    logic            m_busy, m_trap;
    logic [ID_W-1:0] m_id;
    logic [XLEN-1:0] m_pc;
    int              m_age;
    longint          m_smp, m_sex, m_sst;
    logic            m_acc, e_flush, e_rv;

    always_comb begin
        e_flush = m_busy && m_age == 0;
        e_rv    = m_busy && m_age > DRAIN;
        m_acc   = exc_valid_i || (mispred_valid_i &&
                  (!m_busy || (m_age > 0 && !m_trap && older(mispred_id_i, m_id))));
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_trap <= 1'b0; m_id <= '0; m_pc <= '0; m_age <= 0;
            m_smp <= 0; m_sex <= 0; m_sst <= 0;
        end else begin
            if (e_flush && !m_trap) m_smp <= m_smp + 1;
            if (e_flush && m_trap) m_sex <= m_sex + 1;
            if (m_busy) m_sst <= m_sst + 1;
            if (m_acc) begin
                m_busy <= 1'b1;
                m_age  <= 0;
                m_trap <= exc_valid_i;
                m_id   <= mispred_id_i;
                m_pc   <= exc_valid_i ? exc_pc_i : mispred_target_i;
            end else if (e_rv && redirect_ready_i) begin
                m_busy <= 1'b0;
            end else if (m_busy && m_age < 1000) begin
                m_age <= m_age + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_flush", flush_o, e_flush);
            chk("m_flush_all", flush_all_o, e_flush && m_trap);
            chk("m_flush_id", flush_id_o, (e_flush && !m_trap) ? m_id : '0);
            chk("m_stall", stall_o, m_busy);
            chk("m_busy", busy_o, m_busy);
            chk("m_rv", redirect_valid_o, e_rv);
            chk("m_rpc", redirect_pc_o, e_rv ? m_pc : '0);
`ifdef FLUSH_CTRL_STATS_EN
            chk("m_smp", stat_mispred_o, m_smp);
            chk("m_sex", stat_exc_o, m_sex);
            chk("m_sst", stat_stall_o, m_sst);
`else
            chk("m_smp", stat_mispred_o, 0);
            chk("m_sex", stat_exc_o, 0);
            chk("m_sst", stat_stall_o, 0);
`endif
        end
    end

    task automatic clr();
        mispred_valid_i = 1'b0;
        exc_valid_i     = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        clr();
        redirect_ready_i = 1'b1;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic mp(input logic [ID_W-1:0] id, input logic [XLEN-1:0] tgt);
        mispred_valid_i  = 1'b1;
        mispred_id_i     = id;
        mispred_target_i = tgt;
    endtask

    function automatic logic [63:0] st(input logic [63:0] v);
`ifdef FLUSH_CTRL_STATS_EN
        return v;
`else
        return 64'd0 & v;
`endif
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        cyc(1);
        chk("reset_flush", flush_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_stall", stall_o, 0);
        chk("reset_rpc", redirect_pc_o, 0);
        do_reset();

        // Basic mispredict, DRAIN=2
        mp(8'd5, 64'h8000_0040);
        cyc(1); clr();
        chk("t1_flush", flush_o, 1);
        chk("t1_id", flush_id_o, 5);
        chk("t1_all", flush_all_o, 0);
        cyc(1); chk("t1_hold_rv", redirect_valid_o, 0);
        cyc(2);
        chk("t1_rv", redirect_valid_o, 1);
        chk("t1_rpc", redirect_pc_o, 64'h8000_0040);
        cyc(1); chk("t1_idle", busy_o, 0);

        // Trap and mispredict together
        do_reset();
        mp(8'd3, 64'h1234);
        exc_valid_i = 1'b1; exc_pc_i = 64'h8000_0000;
        cyc(1); clr();
        chk("t2_flush", flush_o, 1);
        chk("t2_all", flush_all_o, 1);
        chk("t2_id", flush_id_o, 0);
        cyc(1); chk("t2_single", flush_o, 0);
        cyc(2); chk("t2_rpc", redirect_pc_o, 64'h8000_0000);
        cyc(1);
        chk("t2_idle", busy_o, 0);
        chk("t2_sexc", stat_exc_o, st(1));
        chk("t2_smp", stat_mispred_o, 0);

        // Wrap-around age: 0x02 younger than 0xFE, 0xF0 older
        do_reset();
        mp(8'hFE, 64'hA0);
        cyc(1); clr();
        cyc(1); mp(8'h02, 64'hB0);
        cyc(1); clr();
        chk("t3_ignored", flush_o, 0);
        chk("t3_stall", stall_o, 1);
        mp(8'hF0, 64'hC0);
        cyc(1); clr();
        chk("t3_reflush", flush_o, 1);
        chk("t3_reid", flush_id_o, 8'hF0);
        cyc(3); chk("t3_rpc", redirect_pc_o, 64'hC0);
        cyc(2);

        // Redirect held with ready low for 5 cycles
        do_reset();
        redirect_ready_i = 1'b0;
        mp(8'd9, 64'hDEAD_BEE0);
        cyc(1); clr();
        cyc(3);
        for (int i = 0; i < 5; i++) begin
            chk("t4_rv", redirect_valid_o, 1);
            chk("t4_rpc", redirect_pc_o, 64'hDEAD_BEE0);
            chk("t4_stall", stall_o, 1);
            cyc(1);
        end
        chk("t4_rv6", redirect_valid_o, 1);
        redirect_ready_i = 1'b1;
        cyc(1);
        chk("t4_idle", busy_o, 0);
        chk("t4_sst", stat_stall_o, st(9));

        // Handshake plus older mispredict in same redirect cycle
        do_reset();
        mp(8'h10, 64'h100);
        cyc(1); clr();
        cyc(3);
        chk("t5_rv", redirect_valid_o, 1);
        mp(8'h08, 64'h200);
        cyc(1); clr();
        chk("t5_flush", flush_o, 1);
        chk("t5_id", flush_id_o, 8'h08);
        chk("t5_busy", busy_o, 1);
        cyc(6);

        // Asynchronous reset during drain
        do_reset();
        mp(8'd7, 64'h300);
        cyc(1); clr();
        cyc(1);
        chk("t6_pre", stall_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_stall", stall_o, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_flush", flush_o, 0);
        chk("t6_rv", redirect_valid_o, 0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            chk("t6_norv", redirect_valid_o, 0);
        end

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            mispred_valid_i  = ($urandom % 4) == 0;
            mispred_id_i     = (i % 2 == 0) ? ID_W'($urandom) : ID_W'($urandom_range(0, 7));
            mispred_target_i = {$urandom, $urandom};
            exc_valid_i      = ($urandom % 20) == 0;
            exc_pc_i         = {$urandom, $urandom};
            redirect_ready_i = ($urandom % 3) != 0;
            cyc(1);
        end
        clr();
        redirect_ready_i = 1'b1;
        cyc(10);
        chk("final_idle", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
